bc_msg_arbiter: RTL

Collects broadcast messages from the bc_msg_out channels of all core partitions and round-robin arbitrates them, one per cycle. It then fans the winning message out to every core's bc_msg_in channel as a single registered broadcast. It sits between the per-core PR wrappers and the interconnect. It is both the consumer of bc_msg_out and the producer of bc_msg_in.

---
 rtl/bc_msg_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/bc_msg_arbiter.sv
// Round-robin broadcast message arbiter: one holding slot per core, one broadcast per cycle.
// Optional macro BC_MSG_SRC_ID_EN enables the registered source-core index on m_bc_msg_src.
module bc_msg_arbiter #(
    parameter int CORE_COUNT    = 8,
    parameter int CORE_ID_WIDTH = 3,
    parameter int MSG_WIDTH     = 47
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CORE_COUNT-1:0]           core_reset,
    input  logic [CORE_COUNT*MSG_WIDTH-1:0] s_bc_msg,
    input  logic [CORE_COUNT-1:0]           s_bc_msg_valid,
    output logic [CORE_COUNT-1:0]           s_bc_msg_ready,
    output logic [MSG_WIDTH-1:0]            m_bc_msg,
    output logic [CORE_ID_WIDTH-1:0]        m_bc_msg_src,
    output logic [CORE_COUNT-1:0]           m_bc_msg_valid,
    output logic [31:0]                     bc_msg_count
);

    logic [MSG_WIDTH-1:0]     hold_q [CORE_COUNT];
    logic [CORE_COUNT-1:0]    hold_valid_q, hold_valid_d;
    logic [CORE_COUNT-1:0]    ready_q, ready_d;
    logic [CORE_ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [MSG_WIDTH-1:0]     msg_q;
    logic [CORE_COUNT-1:0]    mvalid_q, mvalid_d;
    logic [31:0]              count_q;

    logic [CORE_COUNT-1:0]    acc;
    logic [CORE_COUNT-1:0]    elig;
    logic [CORE_COUNT-1:0]    gnt_clr;
    logic                     gnt_vld;
    logic [CORE_ID_WIDTH-1:0] gnt_idx;
    logic [CORE_ID_WIDTH-1:0] jj;
    int                       j;

    assign acc  = s_bc_msg_valid & ready_q;
    assign elig = hold_valid_q & ~core_reset;

    // First eligible core at or after the pointer, wrapping at CORE_COUNT.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        j       = 0;
        jj      = '0;
        for (int k = 0; k < CORE_COUNT; k++) begin
            j = int'(ptr_q) + k;
            if (j >= CORE_COUNT) j = j - CORE_COUNT;
            jj = j[CORE_ID_WIDTH-1:0];
            if (!gnt_vld && elig[jj]) begin
                gnt_vld = 1'b1;
                gnt_idx = jj;
            end
        end
    end

    always_comb begin
        gnt_clr = '0;
        ptr_d   = ptr_q;
        if (gnt_vld) begin
            gnt_clr[gnt_idx] = 1'b1;
            if (gnt_idx == CORE_ID_WIDTH'(CORE_COUNT - 1)) ptr_d = '0;
            else ptr_d = gnt_idx + 1'b1;
        end
    end

    // A core in reset loses its pending message and stays non-ready.
    assign hold_valid_d = (hold_valid_q | acc) & ~gnt_clr & ~core_reset;
    assign ready_d      = ~hold_valid_d & ~core_reset;
    assign mvalid_d     = gnt_vld ? ~core_reset : '0;

    always_ff @(posedge clk) begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (acc[i]) hold_q[i] <= s_bc_msg[i*MSG_WIDTH +: MSG_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= '0;
            ready_q      <= '0;
            ptr_q        <= '0;
            msg_q        <= '0;
            mvalid_q     <= '0;
            count_q      <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            ready_q      <= ready_d;
            ptr_q        <= ptr_d;
            mvalid_q     <= mvalid_d;
            if (gnt_vld) begin
                msg_q   <= hold_q[gnt_idx];
                count_q <= count_q + 32'd1;
            end
        end
    end

`ifdef BC_MSG_SRC_ID_EN
    logic [CORE_ID_WIDTH-1:0] src_q;

    always_ff @(posedge clk) begin
        if (rst) src_q <= '0;
        else if (gnt_vld) src_q <= gnt_idx;
    end

    assign m_bc_msg_src = src_q;
`else
    assign m_bc_msg_src = '0;
`endif

    assign s_bc_msg_ready = ready_q;
    assign m_bc_msg       = msg_q;
    assign m_bc_msg_valid = mvalid_q;
    assign bc_msg_count   = count_q;

endmodule
